// File: rtl/m14k_clock_en_ctl_pkg.sv
// Shared types for the per-domain clock-enable controller:
// channel state encoding and hysteresis counter width helper.
package m14k_clock_en_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } ch_state_e;

  function automatic int cnt_w(input int dly);
    int w;
    w = $clog2(dly + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/m14k_clock_en_ch.sv
// One power-domain channel: sleep/wake FSM with idle hysteresis.
// Ports: SI_ClkIn, greset, gscanmode, sleep_req, wake_evt -> ch_en, sleep_ack.
module m14k_clock_en_ch
  import m14k_clock_en_ctl_pkg::*;
#(
  parameter int IDLE_DLY = 8
) (
  input  logic SI_ClkIn,
  input  logic greset,
  input  logic gscanmode,
  input  logic sleep_req,
  input  logic wake_evt,
  output logic ch_en,
  output logic sleep_ack
);

  localparam int CNT_W = cnt_w(IDLE_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_DLY);

  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_idle;

  assign w_idle = sleep_req & ~wake_evt & ~gscanmode;

  always_ff @(posedge SI_ClkIn) begin
    if (greset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt counts idle cycles spent in DRAIN; it stops at CNT_MAX
  // because DRAIN leaves for SLEEP before it could increment past.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_idle) begin
          if (IDLE_DLY == 0) begin
            w_state_nxt = ST_SLEEP;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_idle) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_SLEEP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        if (gscanmode) begin
          w_state_nxt = ST_RUN;
        end else if (wake_evt || !sleep_req) begin
          w_state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        // guaranteed on-cycle before sleep may be considered again
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // scan is the only combinational term so it forces enables immediately
  assign ch_en     = (r_state != ST_SLEEP) | gscanmode;
  assign sleep_ack = (r_state == ST_SLEEP) & ~gscanmode;

endmodule

// File: rtl/m14k_clock_en_ctl.sv
// Per-domain registered clock enables for the never-gated core clock.
// Ports: SI_ClkIn, greset, gscanmode, sleep_req, wake_evt -> ch_en, sleep_ack, all_asleep.
module m14k_clock_en_ctl
  import m14k_clock_en_ctl_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IDLE_DLY = 8
) (
  input  logic              SI_ClkIn,
  input  logic              greset,
  input  logic              gscanmode,
  input  logic [NUM_CH-1:0] sleep_req,
  input  logic [NUM_CH-1:0] wake_evt,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] sleep_ack,
  output logic              all_asleep
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    m14k_clock_en_ch #(
      .IDLE_DLY (IDLE_DLY)
    ) u_ch (
      .SI_ClkIn  (SI_ClkIn),
      .greset    (greset),
      .gscanmode (gscanmode),
      .sleep_req (sleep_req[g]),
      .wake_evt  (wake_evt[g]),
      .ch_en     (ch_en[g]),
      .sleep_ack (sleep_ack[g])
    );
  end

  assign all_asleep = &sleep_ack;

endmodule

// File: tb/tb_m14k_clock_en_ctl.sv
// Bench for m14k_clock_en_ctl: IDLE_DLY=8 and IDLE_DLY=0 builds
// driven together, checked against an idle-streak reference model.
module tb_m14k_clock_en_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan;
  logic [3:0] req;
  logic [3:0] wake;
  logic [3:0] en8, ack8, en0, ack0;
  logic       all8, all0;

  always #5 clk = ~clk;

  m14k_clock_en_ctl #(.NUM_CH(4), .IDLE_DLY(8)) dut8 (
    .SI_ClkIn   (clk),
    .greset     (rst),
    .gscanmode  (scan),
    .sleep_req  (req),
    .wake_evt   (wake),
    .ch_en      (en8),
    .sleep_ack  (ack8),
    .all_asleep (all8)
  );

  m14k_clock_en_ctl #(.NUM_CH(4), .IDLE_DLY(0)) dut0 (
    .SI_ClkIn   (clk),
    .greset     (rst),
    .gscanmode  (scan),
    .sleep_req  (req),
    .wake_evt   (wake),
    .ch_en      (en0),
    .sleep_ack  (ack0),
    .all_asleep (all0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a channel is asleep or awake; awake channels count
  // consecutive idle samples and sleep once the streak is long enough.
  // A channel just woken spends one guard cycle ignoring idle.
  bit m_sleep  [2][4];
  bit m_guard  [2][4];
  int m_streak [2][4];
  int dly [2] = '{8, 0};

  function automatic int need(input int d);
    return (d == 0) ? 1 : d + 2;
  endfunction

  function automatic logic [3:0] exp_en(input int b);
    logic [3:0] e;
    for (int c = 0; c < 4; c++) e[c] = !m_sleep[b][c] || scan;
    return e;
  endfunction

  function automatic logic [3:0] exp_ack(input int b);
    logic [3:0] e;
    for (int c = 0; c < 4; c++) e[c] = m_sleep[b][c] && !scan;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit s,
                            input logic [3:0] q, input logic [3:0] w);
    bit idle;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) begin
        idle = q[c] && !w[c] && !s;
        if (r) begin
          m_sleep[b][c]  = 0;
          m_guard[b][c]  = 0;
          m_streak[b][c] = 0;
        end else if (m_sleep[b][c]) begin
          if (s) begin
            m_sleep[b][c] = 0;
          end else if (w[c] || !q[c]) begin
            m_sleep[b][c] = 0;
            m_guard[b][c] = 1;
          end
          m_streak[b][c] = 0;
        end else if (m_guard[b][c]) begin
          m_guard[b][c]  = 0;
          m_streak[b][c] = 0;
        end else if (idle) begin
          m_streak[b][c]++;
          if (m_streak[b][c] >= need(dly[b])) begin
            m_sleep[b][c]  = 1;
            m_streak[b][c] = 0;
          end
        end else begin
          m_streak[b][c] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input logic [3:0] q,
                     input logic [3:0] w, input bit do_chk);
    rst  = r;
    scan = s;
    req  = q;
    wake = w;
    #1;
    if (do_chk) begin
      chk("en8",  en8,  exp_en(0));
      chk("ack8", ack8, exp_ack(0));
      chk("all8", all8, &exp_ack(0));
      chk("en0",  en0,  exp_en(1));
      chk("ack0", ack0, exp_ack(1));
      chk("all0", all0, &exp_ack(1));
    end
    @(posedge clk);
    model_step(r, s, q, w);
    #1;
  endtask

  int lat8, lat0;

  initial begin
    cyc(1, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'hF, 4'h0, 1);
      chk("rst_en8",  en8,  4'hF);
      chk("rst_ack8", ack8, 4'h0);
      chk("rst_all8", all8, 1'b0);
    end

    // sleep latency, channel 0 only
    lat8 = -1;
    lat0 = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 4'h1, 4'h0, 1);
      if (lat8 < 0 && !en8[0]) lat8 = i;
      if (lat0 < 0 && !en0[0]) lat0 = i;
    end
    chk("lat8", lat8, 9);
    chk("lat0", lat0, 0);
    chk("others8", en8[3:1], 3'b111);
    chk("ack8_ch0", ack8[0], 1'b1);

    // drain abort on channel 1, then a full re-request
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'h3, 4'h0, 1);
    cyc(0, 0, 4'h3, 4'h2, 1);
    chk("abort_en1", en8[1], 1'b1);
    lat8 = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 4'h3, 4'h0, 1);
      if (lat8 < 0 && !en8[1]) lat8 = i;
    end
    chk("relat8", lat8, 9);

    // wake pulse on sleeping channel 2
    for (int i = 0; i < 12; i++) cyc(0, 0, 4'h7, 4'h0, 1);
    chk("slp_ack2", ack8[2], 1'b1);
    cyc(0, 0, 4'h7, 4'h4, 1);
    chk("wake_en2",  en8[2],  1'b1);
    chk("wake_ack2", ack8[2], 1'b0);
    cyc(0, 0, 4'h7, 4'h0, 1);
    chk("guard_en2", en8[2], 1'b1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 4'h7, 4'h0, 1);

    // scan override while fully asleep
    for (int i = 0; i < 12; i++) cyc(0, 0, 4'hF, 4'h0, 1);
    chk("all_asleep8", all8, 1'b1);
    cyc(0, 1, 4'hF, 4'h0, 1);
    lat8 = -1;
    lat0 = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 4'hF, 4'h0, 1);
      if (lat8 < 0 && all8) lat8 = i;
      if (lat0 < 0 && all0) lat0 = i;
    end
    chk("scan_relat8", lat8, 9);
    chk("scan_relat0", lat0, 0);

    // reset while asleep
    cyc(1, 0, 4'hF, 4'h0, 1);
    chk("rst_wake0", en0[3], 1'b1);
    chk("rst_wake8", en8, 4'hF);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] q, w;
      for (int c = 0; c < 4; c++) begin
        q[c] = ($urandom_range(99) < 85);
        w[c] = ($urandom_range(99) < 6);
      end
      cyc(($urandom_range(199) == 0), ($urandom_range(59) == 0),
          q, w, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
